// File: rtl/chunk_refill_controller.sv
// Miss-service engine for the 4-way chunk pool: optional dirty-victim write-back,
// aligned chunk fetch from memory, then a one-cycle install strobe back into the pool.
module chunk_refill_controller #(
  parameter int CHUNK_PART   = 128,
  parameter int ADDRESS_SIZE = 28,
  parameter int OFFSET_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  output logic                    busy,
  output logic                    done,
  input  logic [ADDRESS_SIZE-1:0] save_address,
  input  logic [CHUNK_PART-1:0]   save_data,
  input  logic                    save_need_flag,
  output logic [CHUNK_PART-1:0]   new_data,
  output logic [ADDRESS_SIZE-1:0] new_address,
  output logic                    new_data_save,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_write,
  output logic [ADDRESS_SIZE-1:0] mem_cmd_address,
  output logic [CHUNK_PART-1:0]   mem_cmd_data,
  input  logic                    mem_rsp_valid,
  input  logic [CHUNK_PART-1:0]   mem_rsp_data
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WB_CMD     = 3'd1;
  localparam logic [2:0] FETCH_CMD  = 3'd2;
  localparam logic [2:0] FETCH_WAIT = 3'd3;
  localparam logic [2:0] INSTALL    = 3'd4;

  logic [2:0]              state;
  logic [ADDRESS_SIZE-1:0] fill_addr;
  logic [ADDRESS_SIZE-1:0] req_aligned;

  assign req_aligned = {req_address[ADDRESS_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Control outputs decode straight from the state so they never lag a transition.
  assign busy          = (state != IDLE);
  assign done          = (state == INSTALL);
  assign new_data_save = (state == INSTALL);
  assign mem_cmd_valid = (state == WB_CMD) || (state == FETCH_CMD);
  assign mem_cmd_write = (state == WB_CMD);

  // The victim snapshot lives directly in the command address/data registers,
  // and new_data doubles as the fill register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      fill_addr       <= '0;
      mem_cmd_address <= '0;
      mem_cmd_data    <= '0;
      new_data        <= '0;
      new_address     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            fill_addr <= req_aligned;
            if (save_need_flag) begin
              state           <= WB_CMD;
              mem_cmd_address <= save_address;
              mem_cmd_data    <= save_data;
            end else begin
              state           <= FETCH_CMD;
              mem_cmd_address <= req_aligned;
            end
          end
        end
        WB_CMD: begin
          if (mem_cmd_ready) begin
            state           <= FETCH_CMD;
            mem_cmd_address <= fill_addr;
          end
        end
        FETCH_CMD: begin
          if (mem_cmd_ready) state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (mem_rsp_valid) begin
            new_data    <= mem_rsp_data;
            new_address <= fill_addr;
            state       <= INSTALL;
          end
        end
        INSTALL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_refill_controller.sv
// Directed bench for chunk_refill_controller: per-cycle vector table plus hand
// sequences for reset-during-fetch and request-during-install.
module tb_chunk_refill_controller;

  localparam int CW = 128;
  localparam int AW = 28;

  localparam logic [CW-1:0] D_A5   = {16{8'hA5}};
  localparam logic [CW-1:0] D_5A   = {16{8'h5A}};
  localparam logic [CW-1:0] D_ONES = {32{4'h1}};
  localparam logic [CW-1:0] D_DEAD = {8{16'hDEAD}};
  localparam logic [CW-1:0] D_FF   = {CW{1'b1}};
  localparam logic [CW-1:0] D_C3   = {16{8'hC3}};

  logic          clk = 0;
  logic          reset;
  logic          req_valid;
  logic [AW-1:0] req_address;
  logic          busy, done;
  logic [AW-1:0] save_address;
  logic [CW-1:0] save_data;
  logic          save_need_flag;
  logic [CW-1:0] new_data;
  logic [AW-1:0] new_address;
  logic          new_data_save;
  logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [AW-1:0] mem_cmd_address;
  logic [CW-1:0] mem_cmd_data;
  logic          mem_rsp_valid;
  logic [CW-1:0] mem_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chunk_refill_controller #(.CHUNK_PART(CW), .ADDRESS_SIZE(AW), .OFFSET_BITS(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
    .busy(busy), .done(done), .save_address(save_address), .save_data(save_data),
    .save_need_flag(save_need_flag), .new_data(new_data), .new_address(new_address),
    .new_data_save(new_data_save), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_address(mem_cmd_address), .mem_cmd_data(mem_cmd_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          sf;
    logic [AW-1:0] sa;
    logic [CW-1:0] sd;
    logic          rdy;
    logic          rspv;
    logic [CW-1:0] rspd;
    logic          e_busy, e_done, e_nds, e_cv, e_cw;
    logic [AW-1:0] e_ca;
    logic [CW-1:0] e_cd;
    logic [AW-1:0] e_na;
    logic [CW-1:0] e_nd;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t v(
    input logic rv, input logic [AW-1:0] ra, input logic sf, input logic [AW-1:0] sa,
    input logic [CW-1:0] sd, input logic rdy, input logic rspv, input logic [CW-1:0] rspd,
    input logic e_busy, input logic e_done, input logic e_nds, input logic e_cv,
    input logic e_cw, input logic [AW-1:0] e_ca, input logic [CW-1:0] e_cd,
    input logic [AW-1:0] e_na, input logic [CW-1:0] e_nd);
    vec_t r;
    r.rv = rv; r.ra = ra; r.sf = sf; r.sa = sa; r.sd = sd; r.rdy = rdy;
    r.rspv = rspv; r.rspd = rspd; r.e_busy = e_busy; r.e_done = e_done;
    r.e_nds = e_nds; r.e_cv = e_cv; r.e_cw = e_cw; r.e_ca = e_ca; r.e_cd = e_cd;
    r.e_na = e_na; r.e_nd = e_nd;
    return r;
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_address = '0; save_need_flag = 0; save_address = '0;
    save_data = '0; mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  initial begin
    int lat;
    bit seen;

    //                rv ra        sf sa        sd      rdy rspv rspd    bsy dn nds cv cw ca        cd      na        nd
    // Clean miss
    vecs[0]  = v(1, 28'h0000123, 0, 28'h0,     '0,     1, 0, '0,     0, 0, 0, 0, 0, 28'h0,     '0,     28'h0,     '0);
    vecs[1]  = v(0, 28'h0,       0, 28'h0,     '0,     1, 0, '0,     1, 0, 0, 1, 0, 28'h0000120, '0,   28'h0,     '0);
    vecs[2]  = v(0, 28'h0,       0, 28'h0,     '0,     1, 1, D_A5,   1, 0, 0, 0, 0, 28'h0000120, '0,   28'h0,     '0);
    vecs[3]  = v(0, 28'h0,       0, 28'h0,     '0,     1, 0, '0,     1, 1, 1, 0, 0, 28'h0000120, '0,   28'h0000120, D_A5);
    vecs[4]  = v(0, 28'h0,       0, 28'h0,     '0,     1, 0, '0,     0, 0, 0, 0, 0, 28'h0000120, '0,   28'h0000120, D_A5);
    // Dirty miss with a stray response in IDLE, then 5 cycles of write-back backpressure
    vecs[5]  = v(1, 28'h0000208, 1, 28'h0000400, D_ONES, 0, 1, D_DEAD, 0, 0, 0, 0, 0, 28'h0000120, '0, 28'h0000120, D_A5);
    for (int i = 6; i <= 10; i++)
      vecs[i] = v(0, 28'h0,      0, 28'h00007F0, '0,    0, 1, D_DEAD, 1, 0, 0, 1, 1, 28'h0000400, D_ONES, 28'h0000120, D_A5);
    vecs[11] = v(0, 28'h0,       0, 28'h0,     '0,     1, 0, '0,     1, 0, 0, 1, 1, 28'h0000400, D_ONES, 28'h0000120, D_A5);
    vecs[12] = v(0, 28'h0,       0, 28'h0,     '0,     0, 0, '0,     1, 0, 0, 1, 0, 28'h0000200, D_ONES, 28'h0000120, D_A5);
    vecs[13] = v(0, 28'h0,       0, 28'h0,     '0,     1, 0, '0,     1, 0, 0, 1, 0, 28'h0000200, D_ONES, 28'h0000120, D_A5);
    // Second request while busy must be ignored
    vecs[14] = v(1, 28'h0000999, 0, 28'h0,     '0,     0, 0, '0,     1, 0, 0, 0, 0, 28'h0000200, D_ONES, 28'h0000120, D_A5);
    vecs[15] = v(1, 28'h0000999, 0, 28'h0,     '0,     0, 1, D_5A,   1, 0, 0, 0, 0, 28'h0000200, D_ONES, 28'h0000120, D_A5);
    vecs[16] = v(0, 28'h0,       0, 28'h0,     '0,     0, 0, '0,     1, 1, 1, 0, 0, 28'h0000200, D_ONES, 28'h0000200, D_5A);
    vecs[17] = v(0, 28'h0,       0, 28'h0,     '0,     0, 0, '0,     0, 0, 0, 0, 0, 28'h0000200, D_ONES, 28'h0000200, D_5A);
    vecs[18] = v(0, 28'h0,       0, 28'h0,     '0,     0, 0, '0,     0, 0, 0, 0, 0, 28'h0000200, D_ONES, 28'h0000200, D_5A);

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("reset busy", CW'(busy), CW'(0));
    check("reset cmd_valid", CW'(mem_cmd_valid), CW'(0));
    check("reset new_data_save", CW'(new_data_save), CW'(0));

    // Inputs for cycle i are applied at the negedge; outputs checked there reflect state since the last posedge.
    for (int i = 0; i < 19; i++) begin
      req_valid = vecs[i].rv; req_address = vecs[i].ra; save_need_flag = vecs[i].sf;
      save_address = vecs[i].sa; save_data = vecs[i].sd; mem_cmd_ready = vecs[i].rdy;
      mem_rsp_valid = vecs[i].rspv; mem_rsp_data = vecs[i].rspd;
      check($sformatf("v%0d busy", i), CW'(busy), CW'(vecs[i].e_busy));
      check($sformatf("v%0d done", i), CW'(done), CW'(vecs[i].e_done));
      check($sformatf("v%0d new_data_save", i), CW'(new_data_save), CW'(vecs[i].e_nds));
      check($sformatf("v%0d cmd_valid", i), CW'(mem_cmd_valid), CW'(vecs[i].e_cv));
      check($sformatf("v%0d cmd_write", i), CW'(mem_cmd_write), CW'(vecs[i].e_cw));
      check($sformatf("v%0d cmd_address", i), CW'(mem_cmd_address), CW'(vecs[i].e_ca));
      check($sformatf("v%0d cmd_data", i), mem_cmd_data, vecs[i].e_cd);
      check($sformatf("v%0d new_address", i), CW'(new_address), CW'(vecs[i].e_na));
      check($sformatf("v%0d new_data", i), new_data, vecs[i].e_nd);
      @(negedge clk);
    end

    // Reset while waiting for the fetch response
    idle_inputs();
    req_valid = 1; req_address = 28'h0000345; mem_cmd_ready = 1;
    @(negedge clk);
    req_valid = 0;
    check("rst_seq fetch cmd_address", CW'(mem_cmd_address), CW'(28'h0000340));
    check("rst_seq fetch cmd_valid", CW'(mem_cmd_valid), CW'(1));
    @(negedge clk);
    check("rst_seq in fetch_wait", CW'(busy && !mem_cmd_valid), CW'(1));
    reset = 1;
    @(negedge clk);
    reset = 0;
    mem_rsp_valid = 1; mem_rsp_data = D_FF;
    check("rst_seq busy after reset", CW'(busy), CW'(0));
    check("rst_seq cmd_valid after reset", CW'(mem_cmd_valid), CW'(0));
    check("rst_seq new_address cleared", CW'(new_address), CW'(0));
    check("rst_seq new_data cleared", new_data, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_seq late rsp no strobe %0d", k), CW'(new_data_save), CW'(0));
      check($sformatf("rst_seq late rsp idle %0d", k), CW'(busy), CW'(0));
    end

    // Subsequent clean miss; response data held high so it is taken on the first FETCH_WAIT cycle
    mem_rsp_data = D_C3;
    req_valid = 1; req_address = 28'h0000777;
    seen = 0; lat = 0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      req_valid = 0;
      if (new_data_save) begin
        seen = 1;
        lat = k;
      end
    end
    check("post_rst install seen", CW'(seen), CW'(1));
    check("post_rst latency", CW'(lat), CW'(3));
    check("post_rst new_address", CW'(new_address), CW'(28'h0000770));
    check("post_rst new_data", new_data, D_C3);
    check("post_rst done", CW'(done), CW'(1));

    // Request raised during INSTALL is taken in the following IDLE cycle
    req_valid = 1; req_address = 28'h0000888;
    @(negedge clk);
    check("install_req not yet accepted", CW'(busy), CW'(0));
    @(negedge clk);
    req_valid = 0;
    check("install_req accepted", CW'(busy), CW'(1));
    check("install_req cmd_address", CW'(mem_cmd_address), CW'(28'h0000880));
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (new_data_save) seen = 1;
    end
    check("install_req completes", CW'(seen), CW'(1));
    check("install_req new_address", CW'(new_address), CW'(28'h0000880));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
